// File: rtl/core_sequencer_pkg.sv
// Shared definitions for the core sequencer: FSM states, opcode constants,
// op-class encoding, jump-type definitions and small classification helpers.
package core_sequencer_pkg;

  // Sequencer states; FETCH is the reset state.
  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEM       = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALT      = 3'd5
  } state_e;

  // Instruction class latched at DECODE; OPC_NONE marks "nothing decoded yet".
  typedef enum logic [3:0] {
    OPC_NONE     = 4'd0,
    OPC_LOAD     = 4'd1,
    OPC_STORE    = 4'd2,
    OPC_OP       = 4'd3,
    OPC_OP_IMM   = 4'd4,
    OPC_LUI      = 4'd5,
    OPC_AUIPC    = 4'd6,
    OPC_JAL      = 4'd7,
    OPC_JALR     = 4'd8,
    OPC_BRANCH   = 4'd9,
    OPC_MISC_MEM = 4'd10,
    OPC_SYSTEM   = 4'd11
  } op_class_e;

  // Kind of control transfer an instruction class performs.
  typedef enum logic [1:0] {
    JUMP_NONE   = 2'd0,
    JUMP_JAL    = 2'd1,
    JUMP_JALR   = 2'd2,
    JUMP_BRANCH = 2'd3
  } jump_type_e;

  // Major opcodes, instruction bits [6:0].
  localparam logic [6:0] OPCODE_LOAD     = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE    = 7'b0100011;
  localparam logic [6:0] OPCODE_OP       = 7'b0110011;
  localparam logic [6:0] OPCODE_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPCODE_LUI      = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL      = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR     = 7'b1100111;
  localparam logic [6:0] OPCODE_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPCODE_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPCODE_SYSTEM   = 7'b1110011;

  // Classes that need a data-memory transaction.
  function automatic logic is_mem_class(op_class_e c);
    return (c == OPC_LOAD) || (c == OPC_STORE);
  endfunction

  // Classes that retire straight out of EXECUTE without a register write.
  function automatic logic retires_in_execute(op_class_e c);
    return (c == OPC_BRANCH) || (c == OPC_MISC_MEM);
  endfunction

  // Control-transfer kind of a class.
  function automatic jump_type_e jump_type_of(op_class_e c);
    jump_type_e j;
    case (c)
      OPC_JAL:    j = JUMP_JAL;
      OPC_JALR:   j = JUMP_JALR;
      OPC_BRANCH: j = JUMP_BRANCH;
      default:    j = JUMP_NONE;
    endcase
    return j;
  endfunction

endpackage

// File: rtl/core_sequencer_opcode_classifier.sv
// Combinational opcode classifier: maps the 7-bit major opcode to an op-class
// and flags whether the core supports it at all.
module opcode_classifier
  import core_sequencer_pkg::*;
(
  input  logic [6:0] opcode,
  output op_class_e  op_class,
  output logic       legal
);

  // Decode the major opcode; anything unlisted stays OPC_NONE with legal low.
  always_comb begin
    op_class = OPC_NONE;
    legal    = 1'b1;
    case (opcode)
      OPCODE_LOAD:     op_class = OPC_LOAD;
      OPCODE_STORE:    op_class = OPC_STORE;
      OPCODE_OP:       op_class = OPC_OP;
      OPCODE_OP_IMM:   op_class = OPC_OP_IMM;
      OPCODE_LUI:      op_class = OPC_LUI;
      OPCODE_AUIPC:    op_class = OPC_AUIPC;
      OPCODE_JAL:      op_class = OPC_JAL;
      OPCODE_JALR:     op_class = OPC_JALR;
      OPCODE_BRANCH:   op_class = OPC_BRANCH;
      OPCODE_MISC_MEM: op_class = OPC_MISC_MEM;
      OPCODE_SYSTEM:   op_class = OPC_SYSTEM;
      default:         legal    = 1'b0;
    endcase
  end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle core sequencer: walks each instruction through
// FETCH -> DECODE -> EXECUTE -> [MEM] -> [WRITEBACK], drives the memory
// handshakes and datapath strobes, and counts retired instructions.
// Moore outputs come from registers; ir_load and the store-exit update_pc
// are qualified combinationally by the matching ack. Every output is forced
// low while rst_n is low, so a reset cycle abandons any open request at once.
module core_sequencer
  import core_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req,
  input  logic                  imem_ack,
  output logic                  ir_load,
  input  logic [6:0]            opcode,
  output logic                  dmem_req,
  output logic                  dmem_we,
  input  logic                  dmem_ack,
  output logic                  reg_we,
  output logic                  update_pc,
  output logic                  halt,
  output logic                  illegal,
  output logic [DATA_WIDTH-1:0] instret
);

  state_e                state;
  op_class_e             op_class_q;
  op_class_e             dec_class;
  logic                  dec_legal;
  logic [DATA_WIDTH-1:0] count_q;
  logic                  imem_req_q;
  logic                  dmem_req_q;
  logic                  dmem_we_q;
  logic                  reg_we_q;
  logic                  upc_q;
  logic                  halt_q;
  logic                  illegal_q;
  logic                  store_done;

  opcode_classifier u_classifier (
    .opcode   (opcode),
    .op_class (dec_class),
    .legal    (dec_legal)
  );

  // A store retires in the same cycle its data ack arrives.
  assign store_done = dmem_req_q & dmem_we_q & dmem_ack;

  // Sequencer FSM, registered Moore outputs and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_FETCH;
      op_class_q <= OPC_NONE;
      count_q    <= '0;
      imem_req_q <= 1'b1;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
      reg_we_q   <= 1'b0;
      upc_q      <= 1'b0;
      halt_q     <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      reg_we_q <= 1'b0;
      upc_q    <= 1'b0;
      case (state)
        ST_FETCH: begin
          if (imem_ack) begin
            imem_req_q <= 1'b0;
            state      <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          op_class_q <= dec_class;
          if (!dec_legal) begin
            halt_q    <= 1'b1;
            illegal_q <= 1'b1;
            state     <= ST_HALT;
          end else if (dec_class == OPC_SYSTEM) begin
            halt_q <= 1'b1;
            state  <= ST_HALT;
          end else begin
            upc_q <= retires_in_execute(dec_class);
            state <= ST_EXECUTE;
          end
        end
        ST_EXECUTE: begin
          if (is_mem_class(op_class_q)) begin
            dmem_req_q <= 1'b1;
            dmem_we_q  <= (op_class_q == OPC_STORE);
            state      <= ST_MEM;
          end else if (retires_in_execute(op_class_q)) begin
            count_q    <= count_q + DATA_WIDTH'(1);
            imem_req_q <= 1'b1;
            state      <= ST_FETCH;
          end else begin
            reg_we_q <= 1'b1;
            upc_q    <= 1'b1;
            state    <= ST_WRITEBACK;
          end
        end
        ST_MEM: begin
          if (dmem_ack) begin
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            if (op_class_q == OPC_STORE) begin
              count_q    <= count_q + DATA_WIDTH'(1);
              imem_req_q <= 1'b1;
              state      <= ST_FETCH;
            end else begin
              reg_we_q <= 1'b1;
              upc_q    <= 1'b1;
              state    <= ST_WRITEBACK;
            end
          end
        end
        ST_WRITEBACK: begin
          count_q    <= count_q + DATA_WIDTH'(1);
          imem_req_q <= 1'b1;
          state      <= ST_FETCH;
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
        default: begin
          dmem_req_q <= 1'b0;
          dmem_we_q  <= 1'b0;
          imem_req_q <= 1'b1;
          state      <= ST_FETCH;
        end
      endcase
    end
  end

  assign imem_req  = rst_n & imem_req_q;
  assign ir_load   = rst_n & imem_req_q & imem_ack;
  assign dmem_req  = rst_n & dmem_req_q;
  assign dmem_we   = rst_n & dmem_we_q;
  assign reg_we    = rst_n & reg_we_q;
  assign update_pc = rst_n & (upc_q | store_done);
  assign halt      = rst_n & halt_q;
  assign illegal   = rst_n & illegal_q;
  assign instret   = {DATA_WIDTH{rst_n}} & count_q;

endmodule
